// File: rtl/seq_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
package seq_pkg;

  localparam int          CNT_W   = 4;
  localparam logic [3:0]  PATTERN = 4'b1011;

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_e;

endpackage

// File: rtl/seq_counter.sv
// Wrapping detection counter with asynchronous active-low clear and increment enable.
module seq_counter
  import seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Natural modulo-2^CNT_W wrap; no saturation.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq.sv
// Moore FSM detecting serial pattern 1011 (overlapping), with a running match count.
module seq
  import seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] counter
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Pattern bits are consumed MSB first; mismatches fall back to the longest matching prefix.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = (in == PATTERN[3]) ? S1    : S0;
      S1:      state_d = (in == PATTERN[2]) ? S10   : S1;
      S10:     state_d = (in == PATTERN[1]) ? S101  : S0;
      S101:    state_d = (in == PATTERN[0]) ? S1011 : S10;
      S1011:   state_d = in ? S1 : S10;
      default: state_d = S0;
    endcase
  end

  assign out = (state_q == S1011);

  // Counting on entry to S1011 makes counter change on the same edge out rises.
  seq_counter u_counter (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (state_d == S1011),
    .count_o (counter)
  );

endmodule

// File: tb/tb_seq.sv
// Self-checking bench for seq: directed literal scenarios plus randomized stream vs. a history-based model.
module tb_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in  = 1'b0;
  logic       out;
  logic [3:0] counter;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: a match is simply "the last four sampled bits since reset read 1011".
  logic [3:0] hist_m  = 4'd0;
  int         nb_m    = 0;
  logic       exp_out = 1'b0;
  logic [3:0] exp_cnt = 4'd0;

  seq dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .out     (out),
    .counter (counter)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_m  <= 4'd0;
      nb_m    <= 0;
      exp_out <= 1'b0;
      exp_cnt <= 4'd0;
    end else begin
      hist_m  <= {hist_m[2:0], in};
      nb_m    <= (nb_m < 4) ? nb_m + 1 : 4;
      exp_out <= ({hist_m[2:0], in} == 4'b1011) && (nb_m >= 3);
      exp_cnt <= exp_cnt + ((({hist_m[2:0], in} == 4'b1011) && (nb_m >= 3)) ? 4'd1 : 4'd0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL model_out t=%0t out=%b expected=%b", $time, out, exp_out);
      end
      checks++;
      if (counter !== exp_cnt) begin
        errors++;
        $display("FAIL model_counter t=%0t counter=%0d expected=%0d", $time, counter, exp_cnt);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
    end
  endtask

  // Called at a negedge: drive one bit, wait one cycle, check the literal expectation.
  task automatic step(input logic b, input logic eo, input logic [3:0] ec, input string nm);
    in = b;
    @(negedge clk);
    chk({nm, "_out"}, {3'd0, out}, {3'd0, eo});
    chk({nm, "_cnt"}, counter, ec);
    $display("txn %s in=%b out=%b counter=%0d", nm, b, out, counter);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string nm);
    #2 rst = 1'b0;
    #1;
    chk({nm, "_async_out"}, {3'd0, out}, 4'd0);
    chk({nm, "_async_cnt"}, counter, 4'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [9:0]  ov_bits;
    logic [9:0]  ov_outs;
    logic [5:0]  pf_bits;
    logic [5:0]  pf_outs;
    logic [3:0]  wrap_pat;
    logic [3:0]  cnt_exp;

    ov_bits  = 10'b1011011011;
    ov_outs  = 10'b0001001001;
    pf_bits  = 6'b101011;
    pf_outs  = 6'b000001;
    wrap_pat = 4'b1011;

    rst = 1'b0;
    in  = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;

    // Held in reset with in toggling.
    for (int i = 0; i < 3; i++) begin
      step(logic'(i % 2 == 0), 1'b0, 4'd0, "rst_hold");
    end
    rst = 1'b1;

    // Overlapping stream.
    cnt_exp = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (ov_outs[9-i]) cnt_exp = cnt_exp + 4'd1;
      step(ov_bits[9-i], ov_outs[9-i], cnt_exp, "overlap");
    end
    chk("overlap_final", counter, 4'd3);
    do_reset("rst1");

    // Partial match then fallback.
    cnt_exp = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (pf_outs[5-i]) cnt_exp = cnt_exp + 4'd1;
      step(pf_bits[5-i], pf_outs[5-i], cnt_exp, "fallback");
    end
    chk("fallback_final", counter, 4'd1);
    do_reset("rst2");

    // No false hit.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd0, "nohit_ones");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, "nohit_zeros");
    do_reset("rst3");

    // Reset mid-pattern discards progress.
    step(1'b1, 1'b0, 4'd0, "midrst");
    step(1'b0, 1'b0, 4'd0, "midrst");
    step(1'b1, 1'b0, 4'd0, "midrst");
    do_reset("rst4");
    step(1'b1, 1'b0, 4'd0, "midrst_after");
    do_reset("rst5");

    // Sixteen back-to-back matches wrap the counter to zero.
    cnt_exp = 4'd0;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3) cnt_exp = cnt_exp + 4'd1;
        step(wrap_pat[3-k], logic'(k == 3), cnt_exp, "wrap");
      end
    end
    chk("wrap_final", counter, 4'd0);
    do_reset("rst6");

    // Randomized stream with occasional resets; the model compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset("rand_rst");
      end else begin
        in = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
        if ($urandom_range(0, 2) == 0) in = ~in;
        @(negedge clk);
      end
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
